// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and its datapath/memory.
// mem_read/mem_write are held steady until a cycle with mem_ready=1; that cycle completes the access.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       opcode;
  logic [2:0]       func;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             addr_src;
  logic             reg_write;
  logic             wb_src;
  logic             alu_src_b;
  logic [2:0]       alu_op;
  logic             instr_done;
  logic [CNT_W-1:0] retired;
  logic             trap;
  logic             trap_cause;
  logic [3:0]       state_o;

  modport master (
    input  opcode, func, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, addr_src,
           reg_write, wb_src, alu_src_b, alu_op, instr_done, retired,
           trap, trap_cause, state_o
  );

  modport slave (
    output opcode, func, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, addr_src,
           reg_write, wb_src, alu_src_b, alu_op, instr_done, retired,
           trap, trap_cause, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the 16-bit multi-cycle processor: fetch/decode/execute/memory/writeback
// sequencing, memory-wait timeout, illegal-opcode trap and retired-instruction counting.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst_n,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEM_RD = 4'd2,
    S_MEM_WB = 4'd3,
    S_MEM_WR = 4'd4,
    S_JUMP   = 4'd5,
    S_BRZ    = 4'd6,
    S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8,
    S_ALU_WB = 4'd9,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [7:0] TMO_LIM = 8'(MEM_TIMEOUT);

  state_t           state, state_nx;
  logic [7:0]       tmo, tmo_nx;
  logic             cause_q, cause_nx;
  logic [2:0]       alu_op_q;
  logic [CNT_W-1:0] retired_q;
  logic             mem_wait, tmo_hit;

  logic       pc_write, ir_write, mem_read, mem_write, addr_src;
  logic       reg_write, wb_src, alu_src_b, instr_done;
  logic [1:0] pc_src;
  logic [2:0] alu_op;

  // A ready on the limit cycle still completes the access: tmo_hit is only consulted without ready.
  always_comb begin
    mem_wait = (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR) && !bus.mem_ready;
    tmo_hit  = mem_wait && ((tmo + 8'd1) == TMO_LIM);
    tmo_nx   = (mem_wait && !tmo_hit) ? tmo + 8'd1 : 8'd0;
  end

  always_comb begin
    state_nx   = state;
    cause_nx   = cause_q;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_src   = 1'b0;
    reg_write  = 1'b0;
    wb_src     = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 3'b000;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end else if (tmo_hit) begin
          state_nx = S_TRAP;
          cause_nx = 1'b1;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          4'b0000: state_nx = S_MEM_RD;
          4'b0001: state_nx = S_MEM_WR;
          4'b0010: state_nx = S_JUMP;
          4'b0100: state_nx = S_BRZ;
          4'b1000: begin
            if (bus.func >= 3'd5) begin
              state_nx = S_TRAP;
              cause_nx = 1'b0;
            end else begin
              state_nx = S_EXEC_R;
            end
          end
          4'b1100, 4'b1101, 4'b1110, 4'b1111: state_nx = S_EXEC_I;
          default: begin
            state_nx = S_TRAP;
            cause_nx = 1'b0;
          end
        endcase
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        addr_src = 1'b1;
        if (bus.mem_ready) begin
          state_nx = S_MEM_WB;
        end else if (tmo_hit) begin
          state_nx = S_TRAP;
          cause_nx = 1'b1;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        wb_src     = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        addr_src  = 1'b1;
        if (bus.mem_ready) begin
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end else if (tmo_hit) begin
          state_nx = S_TRAP;
          cause_nx = 1'b1;
        end
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b01;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_BRZ: begin
        pc_write   = bus.zero;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_EXEC_R: begin
        alu_op   = bus.func;
        state_nx = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_b = 1'b1;
        alu_op    = {1'b0, bus.opcode[1:0]};
        state_nx  = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        alu_op     = alu_op_q;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_TRAP: state_nx = S_TRAP;
      // Unused encodings can only come from upset state bits; park them in TRAP.
      default: begin
        state_nx = S_TRAP;
        cause_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      tmo       <= 8'd0;
      cause_q   <= 1'b0;
      alu_op_q  <= 3'b000;
      retired_q <= '0;
    end else begin
      state   <= state_nx;
      tmo     <= tmo_nx;
      cause_q <= cause_nx;
      if (state == S_EXEC_R || state == S_EXEC_I) alu_op_q <= alu_op;
      if (instr_done) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.ir_write   = ir_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.addr_src   = addr_src;
  assign bus.reg_write  = reg_write;
  assign bus.wb_src     = wb_src;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.instr_done = instr_done;
  assign bus.retired    = retired_q;
  assign bus.trap       = (state == S_TRAP);
  assign bus.trap_cause = cause_q;
  assign bus.state_o    = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction table plus hand sequences for wait states,
// timeout boundary, traps and reset during a memory access.
module tb_multicycle_ctrl;
  localparam int CNT_W       = 16;
  localparam int MEM_TIMEOUT = 15;
  localparam int W           = 26;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus();
  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [3:0]  opc;
    logic [2:0]  fn;
    logic        z;
    int          wt;
    logic [3:0]  st;
    logic [13:0] ctl;
    int          cyc;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [13:0] mk_ctl(logic pw, logic [1:0] ps, logic irw, logic mr, logic mw,
                                         logic as, logic rw, logic wb, logic asb, logic [2:0] aop,
                                         logic done);
    return {pw, ps, irw, mr, mw, as, rw, wb, asb, aop, done};
  endfunction

  function automatic logic [13:0] cur_ctl();
    return {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write, bus.addr_src,
            bus.reg_write, bus.wb_src, bus.alu_src_b, bus.alu_op, bus.instr_done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Advance one cycle with memory idle and sample at the falling edge.
  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
  endtask

  // Driver + memory model: fetches complete at once, data accesses after wt wait cycles.
  // The expected {final state, final controls, cycle count} is queued before driving.
  task automatic drive(input logic [3:0] opc, input logic [2:0] fn, input logic z, input int wt,
                       input logic [3:0] st, input logic [13:0] ctl, input int exp_cyc,
                       input string name, output int dreq_n, output logic [13:0] exec_ctl);
    int cyc;
    int dcnt;
    logic done_seen;
    logic trap_seen;
    logic [W-1:0] exp;
    exp_q.push_back({st, ctl, 8'(exp_cyc)});
    cyc = 0; dcnt = 0; dreq_n = 0; exec_ctl = '0;
    done_seen = 1'b0; trap_seen = 1'b0;
    bus.opcode = opc; bus.func = fn; bus.zero = z;
    while (!done_seen && !trap_seen && cyc < 64) begin
      @(posedge clk); #1;
      if ((bus.mem_read || bus.mem_write) && bus.addr_src) begin
        bus.mem_ready = (dcnt >= wt);
        dcnt++;
        dreq_n++;
      end else begin
        bus.mem_ready = bus.mem_read;
      end
      @(negedge clk);
      cyc++;
      if (bus.state_o == 4'd7 || bus.state_o == 4'd8) exec_ctl = cur_ctl();
      done_seen = bus.instr_done;
      trap_seen = bus.trap;
    end
    if (!done_seen && !trap_seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_budget: no completion after %0d cycles, required one", name, cyc);
    end
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_queue: expected queue empty, required an entry", name);
    end else begin
      exp = exp_q.pop_front();
      check(name, {bus.state_o, cur_ctl(), 8'(cyc)}, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int dq;
    int w;
    int k;
    int in_wr;
    logic reached;
    logic [13:0] ec;
    logic [13:0] c_load, c_store, c_none;

    c_load  = mk_ctl(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 3'd0, 1);
    c_store = mk_ctl(0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 3'd0, 1);
    c_none  = '0;
    tbl[0]  = '{4'h2, 3'd0, 1'b0, 0, 4'd5, mk_ctl(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1), 3};
    tbl[1]  = '{4'h4, 3'd0, 1'b1, 0, 4'd6, mk_ctl(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1), 3};
    tbl[2]  = '{4'h4, 3'd0, 1'b0, 0, 4'd6, mk_ctl(0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1), 3};
    tbl[3]  = '{4'h0, 3'd0, 1'b0, 3, 4'd3, c_load, 7};
    tbl[4]  = '{4'h1, 3'd0, 1'b0, 0, 4'd4, c_store, 3};
    tbl[5]  = '{4'h1, 3'd0, 1'b0, 2, 4'd4, c_store, 5};
    tbl[6]  = '{4'hC, 3'd0, 1'b0, 0, 4'd9, mk_ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3'd0, 1), 4};
    tbl[7]  = '{4'hD, 3'd0, 1'b0, 0, 4'd9, mk_ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3'd1, 1), 4};
    tbl[8]  = '{4'hE, 3'd0, 1'b0, 0, 4'd9, mk_ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3'd2, 1), 4};
    tbl[9]  = '{4'hF, 3'd0, 1'b0, 0, 4'd9, mk_ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3'd3, 1), 4};
    tbl[10] = '{4'h8, 3'd1, 1'b0, 0, 4'd9, mk_ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3'd1, 1), 4};
    tbl[11] = '{4'h8, 3'd4, 1'b0, 0, 4'd9, mk_ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3'd4, 1), 4};
    tbl[12] = '{4'h8, 3'd3, 1'b0, 0, 4'd9, mk_ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3'd3, 1), 4};
    tbl[13] = '{4'h0, 3'd0, 1'b0, 0, 4'd3, c_load, 4};

    bus.opcode = 4'h0; bus.func = 3'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    check("reset_state", 32'(bus.state_o), 32'd0);
    check("reset_ctl", 32'(cur_ctl()), 32'(mk_ctl(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 3'd0, 0)));
    check("reset_retired", 32'(bus.retired), 32'd0);
    check("reset_trap", {30'd0, bus.trap, bus.trap_cause}, 32'd0);

    for (int i = 0; i < 14; i++)
      drive(tbl[i].opc, tbl[i].fn, tbl[i].z, tbl[i].wt, tbl[i].st, tbl[i].ctl, tbl[i].cyc,
            $sformatf("vec%0d", i), dq, ec);

    for (int i = 0; i < 10; i++) begin
      w = int'($urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1)
        drive(4'h0, 3'd0, 1'b0, w, 4'd3, c_load, 4 + w, $sformatf("rnd_load%0d", i), dq, ec);
      else
        drive(4'h1, 3'd0, 1'b0, w, 4'd4, c_store, 3 + w, $sformatf("rnd_store%0d", i), dq, ec);
    end
    idle_cycle();
    check("retired_24", 32'(bus.retired), 32'd24);

    // Reset while a store is waiting on memory.
    bus.opcode = 4'h1;
    k = 0; in_wr = 0; reached = 1'b0;
    while (k < 20 && !reached) begin
      @(posedge clk); #1;
      bus.mem_ready = bus.mem_read && !bus.addr_src;
      k++;
      if (bus.state_o == 4'd4) in_wr++;
      if (in_wr == 2) reached = 1'b1;
    end
    check("midwr_reached", 32'(reached), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("midwr_mem_write", 32'(bus.mem_write), 32'd0);
    check("midwr_state", 32'(bus.state_o), 32'd0);
    check("midwr_retired", 32'(bus.retired), 32'd0);

    drive(4'h0, 3'd0, 1'b0, 3, 4'd3, c_load, 7, "load_wait3", dq, ec);
    check("load_wait3_req_cycles", 32'(dq), 32'd4);
    drive(4'hC, 3'd0, 1'b0, 0, 4'd9, mk_ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3'd0, 1), 4,
          "addi", dq, ec);
    check("addi_exec", 32'(ec), 32'(mk_ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 3'd0, 0)));
    drive(4'h8, 3'd1, 1'b0, 0, 4'd9, mk_ctl(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 3'd1, 1), 4,
          "rsub", dq, ec);
    check("rsub_exec", 32'(ec), 32'(mk_ctl(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0)));
    idle_cycle();
    check("retired_3", 32'(bus.retired), 32'd3);

    do_reset();
    drive(4'h3, 3'd0, 1'b0, 0, 4'd15, c_none, 3, "illegal_op3", dq, ec);
    check("op3_trap", {30'd0, bus.trap, bus.trap_cause}, 32'b10);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("trap_hold%0d", i), {bus.state_o, cur_ctl()}, {4'd15, 14'd0});
    end
    do_reset();
    check("trap_reset_state", 32'(bus.state_o), 32'd0);
    check("trap_reset_trap", 32'(bus.trap), 32'd0);

    drive(4'h8, 3'd6, 1'b0, 0, 4'd15, c_none, 3, "illegal_func6", dq, ec);
    check("func6_trap", {30'd0, bus.trap, bus.trap_cause}, 32'b10);
    do_reset();

    drive(4'h1, 3'd0, 1'b0, MEM_TIMEOUT - 1, 4'd4, c_store, 3 + MEM_TIMEOUT - 1,
          "store_ready_at_limit", dq, ec);
    drive(4'h1, 3'd0, 1'b0, 1000, 4'd15, c_none, 3 + MEM_TIMEOUT, "store_timeout", dq, ec);
    check("timeout_trap", {30'd0, bus.trap, bus.trap_cause}, 32'b11);
    do_reset();
    check("timeout_reset_cause", {30'd0, bus.trap, bus.trap_cause}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
